piso_serializer: RTL and testbench

Parameterised parallel-in/serial-out serializer with valid/ready handshakes on both sides. It accepts a WIDTH-bit word from an upstream producer and emits it one bit per accepted serial transfer, LSB- or MSB-first. It supports downstream back-pressure, a last-bit marker, and back-to-back words without bubbles. It is the general serializer for the team's serial link and test datapaths.

---
 rtl/piso_pkg.sv | 11 +
 rtl/piso_serializer.sv | 71 +++++++
 tb/tb_piso_serializer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic {IDLE, SHIFT} piso_state_t;

  // Bit-counter width; never below one bit so WIDTH=1 still has a legal counter.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready on both sides and a last-bit marker.
// Back-to-back words stream without a bubble at one bit per cycle.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] par_data_i,
  input  logic             par_valid_i,
  output logic             par_ready_o,
  output logic             ser_data_o,
  output logic             ser_valid_o,
  input  logic             ser_ready_i,
  output logic             ser_last_o,
  output logic             busy_o,
  output logic             empty_o
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(WIDTH - 1);

  piso_state_t      r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;

  logic             w_ser_hs;
  logic             w_cnt_zero;
  logic [WIDTH-1:0] w_shifted;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_ser_hs   = ser_valid_o && ser_ready_i;
  // Zero-filled shift toward whichever end drives ser_data_o.
  assign w_shifted  = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);

  assign ser_valid_o = (r_state == SHIFT);
  assign ser_data_o  = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign ser_last_o  = (r_state == SHIFT) && w_cnt_zero;
  assign busy_o      = (r_state == SHIFT);
  assign empty_o     = !busy_o;
  // Combinational from ser_ready_i so a new word can load on the last-bit handshake.
  assign par_ready_o = (r_state == IDLE) || (ser_last_o && ser_ready_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (r_state == IDLE) begin
      if (par_valid_i) begin
        r_state <= SHIFT;
        r_shreg <= par_data_i;
        r_cnt   <= CntLoad;
      end
    end else if (w_ser_hs) begin
      if (!w_cnt_zero) begin
        r_shreg <= w_shifted;
        r_cnt   <= r_cnt - CNT_W'(1);
      end else if (par_valid_i) begin
        r_shreg <= par_data_i;
        r_cnt   <= CntLoad;
      end else begin
        r_state <= IDLE;
        r_shreg <= w_shifted;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (W4 LSB-first, W8 MSB-first, W1) driven
// from a vector table plus hand-written back-pressure, back-to-back, reset and W1 sequences.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] par_data  [3];
  logic       par_valid [3];
  logic       ser_ready [3];
  logic       par_ready [3];
  logic       ser_data  [3];
  logic       ser_valid [3];
  logic       ser_last  [3];
  logic       busy      [3];
  logic       empty     [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_w4 (
    .clk(clk), .reset(reset), .par_data_i(par_data[0][3:0]), .par_valid_i(par_valid[0]),
    .par_ready_o(par_ready[0]), .ser_data_o(ser_data[0]), .ser_valid_o(ser_valid[0]),
    .ser_ready_i(ser_ready[0]), .ser_last_o(ser_last[0]), .busy_o(busy[0]), .empty_o(empty[0])
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_w8 (
    .clk(clk), .reset(reset), .par_data_i(par_data[1]), .par_valid_i(par_valid[1]),
    .par_ready_o(par_ready[1]), .ser_data_o(ser_data[1]), .ser_valid_o(ser_valid[1]),
    .ser_ready_i(ser_ready[1]), .ser_last_o(ser_last[1]), .busy_o(busy[1]), .empty_o(empty[1])
  );

  piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b0)) u_w1 (
    .clk(clk), .reset(reset), .par_data_i(par_data[2][0:0]), .par_valid_i(par_valid[2]),
    .par_ready_o(par_ready[2]), .ser_data_o(ser_data[2]), .ser_valid_o(ser_valid[2]),
    .ser_ready_i(ser_ready[2]), .ser_last_o(ser_last[2]), .busy_o(busy[2]), .empty_o(empty[2])
  );

  // exp_bits[i] is the i-th bit expected on ser_data_o.
  typedef struct {
    int unsigned dut;
    logic [7:0]  word;
    logic [7:0]  exp_bits;
    int unsigned nbits;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input int unsigned d, input string tag);
    chk({tag, " ser_valid"}, 32'(ser_valid[d]), 32'd0);
    chk({tag, " ser_last"},  32'(ser_last[d]),  32'd0);
    chk({tag, " busy"},      32'(busy[d]),      32'd0);
    chk({tag, " empty"},     32'(empty[d]),     32'd1);
    chk({tag, " par_ready"}, 32'(par_ready[d]), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk("load par_ready", 32'(par_ready[v.dut]), 32'd1);
    par_valid[v.dut] = 1'b1;
    par_data[v.dut]  = v.word;
    @(negedge clk);
    par_valid[v.dut] = 1'b0;
    par_data[v.dut]  = 8'h00;
    for (int i = 0; i < int'(v.nbits); i++) begin
      chk($sformatf("vec %0h bit%0d valid", v.word, i), 32'(ser_valid[v.dut]), 32'd1);
      chk($sformatf("vec %0h bit%0d data", v.word, i), 32'(ser_data[v.dut]),
          32'(v.exp_bits[i]));
      chk($sformatf("vec %0h bit%0d last", v.word, i), 32'(ser_last[v.dut]),
          32'(i == int'(v.nbits) - 1));
      @(negedge clk);
    end
    check_idle(v.dut, "post-word");
  endtask

  vec_t vecs [5];

  initial begin
    logic [7:0] bits;
    vecs[0] = '{dut: 0, word: 8'h0B, exp_bits: 8'h0B, nbits: 4};  // 1,1,0,1
    vecs[1] = '{dut: 1, word: 8'hA5, exp_bits: 8'hA5, nbits: 8};  // 1,0,1,0,0,1,0,1
    vecs[2] = '{dut: 1, word: 8'hC1, exp_bits: 8'h83, nbits: 8};  // 1,1,0,0,0,0,0,1
    vecs[3] = '{dut: 0, word: 8'h06, exp_bits: 8'h06, nbits: 4};  // 0,1,1,0
    vecs[4] = '{dut: 2, word: 8'h01, exp_bits: 8'h01, nbits: 1};

    for (int d = 0; d < 3; d++) begin
      par_data[d]  = 8'h00;
      par_valid[d] = 1'b0;
      ser_ready[d] = 1'b1;
    end
    reset = 1'b1;
    #12;
    for (int d = 0; d < 3; d++) begin
      check_idle(d, "reset");
      chk("reset ser_data", 32'(ser_data[d]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Back-pressure: stall two cycles on the second bit of 0110.
    @(negedge clk);
    par_valid[0] = 1'b1;
    par_data[0]  = 8'h06;
    @(negedge clk);
    par_valid[0] = 1'b0;
    bits = 8'h06;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        ser_ready[0] = 1'b0;
        for (int s = 0; s < 2; s++) begin
          chk("stall valid", 32'(ser_valid[0]), 32'd1);
          chk("stall data", 32'(ser_data[0]), 32'd1);
          chk("stall last", 32'(ser_last[0]), 32'd0);
          chk("stall par_ready", 32'(par_ready[0]), 32'd0);
          @(negedge clk);
        end
        ser_ready[0] = 1'b1;
      end
      chk($sformatf("bp bit%0d data", i), 32'(ser_data[0]), 32'(bits[i]));
      chk($sformatf("bp bit%0d last", i), 32'(ser_last[0]), 32'(i == 3));
      chk($sformatf("bp bit%0d par_ready", i), 32'(par_ready[0]), 32'(i == 3));
      @(negedge clk);
    end
    check_idle(0, "bp end");

    // Back-to-back: 4'h3 then 4'hC with par_valid held.
    @(negedge clk);
    par_valid[0] = 1'b1;
    par_data[0]  = 8'h03;
    @(negedge clk);
    par_data[0] = 8'h0C;
    bits = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) par_valid[0] = 1'b0;
      chk($sformatf("b2b cyc%0d valid", i + 1), 32'(ser_valid[0]), 32'd1);
      chk($sformatf("b2b cyc%0d data", i + 1), 32'(ser_data[0]), 32'(bits[i]));
      chk($sformatf("b2b cyc%0d last", i + 1), 32'(ser_last[0]), 32'(i == 3 || i == 7));
      if (i < 4) chk($sformatf("b2b cyc%0d par_ready", i + 1), 32'(par_ready[0]), 32'(i == 3));
      @(negedge clk);
    end
    check_idle(0, "b2b end");

    // Reset mid-word, then a fresh word must come out clean.
    @(negedge clk);
    par_valid[1] = 1'b1;
    par_data[1]  = 8'hFF;
    @(negedge clk);
    par_valid[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("pre-reset data", 32'(ser_data[1]), 32'd1);
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check_idle(1, "mid-reset");
    chk("mid-reset ser_data", 32'(ser_data[1]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_vec('{dut: 1, word: 8'h01, exp_bits: 8'h80, nbits: 8});

    // WIDTH=1 streaming 1,0,1 with par_valid held.
    @(negedge clk);
    par_valid[2] = 1'b1;
    par_data[2]  = 8'h01;
    bits = 8'h05;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      par_data[2] = (i == 0) ? 8'h00 : 8'h01;
      if (i == 2) par_valid[2] = 1'b0;
      chk($sformatf("w1 cyc%0d valid", i + 1), 32'(ser_valid[2]), 32'd1);
      chk($sformatf("w1 cyc%0d data", i + 1), 32'(ser_data[2]), 32'(bits[i]));
      chk($sformatf("w1 cyc%0d last", i + 1), 32'(ser_last[2]), 32'd1);
      chk($sformatf("w1 cyc%0d par_ready", i + 1), 32'(par_ready[2]), 32'd1);
    end
    @(negedge clk);
    check_idle(2, "w1 end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
